spi_frame_reader: RTL and testbench
===================================

# spi_frame_reader

SPI master that drains one stored frame from the frame buffer over its SPI read port. It sequences the frame buffer's read protocol (CAPTURE_READ preamble, then data clocking), generates SPI_CLK from SYSCLK, deserialises SPI_MISO MSB-first into bytes, and presents them on a valid/ready byte stream to the downstream consumer. Backpressure stalls SPI_CLK, so no data is lost.

## Interface
- CLK_DIV, 1: SYSCLK cycles per SPI_CLK phase; high and low phases are equal. Legal range is 1..255.
- PREAMBLE_CLKS, 8: SPI_CLK pulses issued while CAPTURE_READ=1.
- GAP_CYCLES, 1: extra SYSCLK cycles with SPI_CLK low between the preamble and data. Legal range is 0..255.
- FRAME_BYTES, 9: bytes read per frame. Must be ≥1.

Ports:
- SYSCLK  in  1  system clock; the only clock; all logic on its rising edge.
- NSYSRESET  in  1  asynchronous, active-low reset.
- START  in  1  level; sampled only in IDLE; begins one frame read.
- SPI_MISO  in  1  serial data from the frame buffer.
- SPI_CLK  out  1  SPI clock; idles low; registered output.
- CAPTURE_READ  out  1  high during the preamble; registered.
- PIX_DATA  out  8  received byte; stable while PIX_VALID=1.
- PIX_VALID  out  1  byte available.
- PIX_READY  in  1  consumer accepts; a transfer occurs when PIX_VALID && PIX_READY on a rising edge.
- BUSY  out  1  high from the cycle after START acceptance until DONE.
- DONE  out  1  one-cycle pulse at the end of a frame.

## Operation
- **States:** IDLE, SETUP, PREAMBLE, GAP, SHIFT, FINISH.
- **IDLE:**
  - Outputs SPI_CLK=0, CAPTURE_READ=0, BUSY=0.
  - START=1 moves the block to SETUP.
- **SETUP:**
  - Lasts one cycle.
  - CAPTURE_READ=1, BUSY=1, SPI_CLK=0.
- **PREAMBLE:**
  - Issues PREAMBLE_CLKS pulses, each consisting of CLK_DIV cycles high followed by CLK_DIV cycles low.
  - SPI_MISO is ignored.
  - CAPTURE_READ falls with the final falling edge.
- **GAP:**
  - Holds SPI_CLK low for GAP_CYCLES cycles.
  - When GAP_CYCLES=0, this state is skipped.
- **SHIFT:**
  - Clocks 8 pulses per byte.
  - SPI_MISO is sampled on the SYSCLK edge that ends each high phase, i.e. the edge driving SPI_CLK low.
  - Bits are shifted in MSB first.
  - After the 8th sample, the byte loads into PIX_DATA and PIX_VALID is set on the following cycle.
- **Stall rule:**
  - The 8th pulse of a byte must not start (SPI_CLK must not rise) while PIX_VALID=1 and PIX_READY=0.
  - During a stall, SPI_CLK stays low and the 7 bits already shifted are held.
  - Pulses 1–7 of the next byte proceed while the previous byte waits.
- **Frame end:**
  - After FRAME_BYTES bytes are loaded, the block enters FINISH.
  - FINISH waits for the last byte to be accepted.
  - DONE=1 for one cycle in the cycle after that transfer, then IDLE.
  - BUSY drops in the same cycle as DONE.
- **Counter widths:**
  - Byte counter: $clog2(FRAME_BYTES+1).
  - Bit counter: 3 bits.
  - Phase counter: 8 bits.
  - Pulse counter: $clog2(PREAMBLE_CLKS+1).
  - No counter wraps within a frame.
- **START:**
  - Ignored when not in IDLE.
  - If START is held high through DONE, a new frame begins on the cycle after returning to IDLE.
- **Reset:**
  - Asserting NSYSRESET at any time, including mid-byte, immediately forces every output to 0 (SPI_CLK, CAPTURE_READ, PIX_DATA=8'h00, PIX_VALID, BUSY, DONE), clears all counters, and returns the state to IDLE.
  - A partial frame is discarded.

## Timing
Cycle numbers are given for CLK_DIV=1, PREAMBLE_CLKS=8, GAP_CYCLES=1, with START sampled at the end of cycle 0.
- **Cycle 1:** SETUP; CAPTURE_READ=1.
- **Cycles 2,4,…,16:** SPI_CLK high.
- **Cycle 17:** SPI_CLK low and CAPTURE_READ=0.
- **Cycle 18:** gap.
- **Cycles 19,21,…,33:** data pulses for byte 0; SPI_MISO is sampled at the end of each of these cycles.
- **Cycle 34:** PIX_VALID=1 with byte 0.
- **Unstalled throughput:** one byte per 16·CLK_DIV cycles.
- **Latency from 8th sample to PIX_VALID:** 1 cycle.
- **PIX_DATA and PIX_VALID:** registered; PIX_VALID falls the cycle after acceptance unless a new byte is loaded in that same cycle.

## Test plan
- **Nominal (default parameters, PIX_READY=1):** a MISO model serves 0xA5,0x3C,0xFF,0x00,0x81,0x7E,0x12,0x34,0xC3 -> exactly 8 CAPTURE_READ pulses and then 72 data pulses; those 9 bytes emitted in order; byte 0 valid in cycle 34; one DONE pulse; BUSY low afterwards.
- **Backpressure:** PIX_READY=0 for 20 cycles after byte 0 is valid -> SPI_CLK stays low after the 7th pulse of byte 1; PIX_DATA holds 0xA5; after release all 9 bytes are correct.
- **Last-byte hold:** PIX_READY=0 when byte 8 becomes valid -> no DONE until acceptance; DONE is then a single pulse.
- **START handling:** pulse START mid-frame -> ignored; hold START high -> back-to-back frames, each starting with a preamble.
- **Reset mid-frame:** drop NSYSRESET during byte 3 -> all outputs 0 in the same cycle; after release the block stays idle until START, and the next frame is complete and correct.
- **CLK_DIV=3, GAP_CYCLES=0:** phases of 3 cycles each; no gap cycle; 9 bytes correct; one byte every 48 cycles.

Source files
------------

// File: rtl/spi_frame_reader.sv
// SPI master that reads one stored frame (CAPTURE_READ preamble, then data bytes)
// and streams the received bytes out on a valid/ready byte interface.
module spi_frame_reader #(
  parameter int CLK_DIV       = 1,
  parameter int PREAMBLE_CLKS = 8,
  parameter int GAP_CYCLES    = 1,
  parameter int FRAME_BYTES   = 9
) (
  input  logic       SYSCLK,
  input  logic       NSYSRESET,
  input  logic       START,
  input  logic       SPI_MISO,
  output logic       SPI_CLK,
  output logic       CAPTURE_READ,
  output logic [7:0] PIX_DATA,
  output logic       PIX_VALID,
  input  logic       PIX_READY,
  output logic       BUSY,
  output logic       DONE,
  output logic [2:0] state_dbg
);

  // Byte stream handshake: a byte moves on any rising SYSCLK edge where
  // PIX_VALID && PIX_READY; PIX_DATA is held while PIX_VALID is high and
  // PIX_VALID never depends combinationally on PIX_READY.

  typedef enum logic [2:0] {IDLE, SETUP, PREAMBLE, GAP, SHIFT, FINISH} state_t;

  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam int PW = $clog2(PREAMBLE_CLKS + 1);
  localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PREAMBLE_CLKS - 1);
  localparam logic [PW-1:0] PULSE_ALL  = PW'(PREAMBLE_CLKS);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(FRAME_BYTES - 1);

  state_t        state;
  logic [7:0]    phase_cnt;
  logic [PW-1:0] pulse_cnt;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [6:0]    shreg;
  logic          phase_end;
  logic          stall;

  assign phase_end = (phase_cnt == DIV_LAST);
  // The 8th pulse would load a byte on top of one the consumer has not taken.
  assign stall     = PIX_VALID && !PIX_READY && (bit_cnt == 3'd7);
  assign state_dbg = state;

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state        <= IDLE;
      SPI_CLK      <= 1'b0;
      CAPTURE_READ <= 1'b0;
      PIX_DATA     <= 8'h00;
      PIX_VALID    <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      phase_cnt    <= 8'd0;
      pulse_cnt    <= '0;
      bit_cnt      <= 3'd0;
      byte_cnt     <= '0;
      shreg        <= 7'd0;
    end else begin
      DONE <= 1'b0;
      if (PIX_VALID && PIX_READY) PIX_VALID <= 1'b0;

      case (state)
        IDLE: begin
          if (START) begin
            state        <= SETUP;
            CAPTURE_READ <= 1'b1;
            BUSY         <= 1'b1;
            phase_cnt    <= 8'd0;
            pulse_cnt    <= '0;
            bit_cnt      <= 3'd0;
            byte_cnt     <= '0;
          end
        end

        SETUP: begin
          state     <= PREAMBLE;
          SPI_CLK   <= 1'b1;
          phase_cnt <= 8'd0;
        end

        PREAMBLE: begin
          if (phase_end) begin
            phase_cnt <= 8'd0;
            if (SPI_CLK) begin
              SPI_CLK   <= 1'b0;
              pulse_cnt <= pulse_cnt + 1'b1;
              if (pulse_cnt == PULSE_LAST) CAPTURE_READ <= 1'b0;
            end else if (pulse_cnt == PULSE_ALL) begin
              if (GAP_CYCLES == 0) begin
                state   <= SHIFT;
                SPI_CLK <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else begin
              SPI_CLK <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        GAP: begin
          if (phase_cnt == GAP_LAST) begin
            phase_cnt <= 8'd0;
            state     <= SHIFT;
            SPI_CLK   <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        SHIFT: begin
          if (phase_end) begin
            if (SPI_CLK) begin
              // End of a high phase: this edge samples MISO.
              phase_cnt <= 8'd0;
              SPI_CLK   <= 1'b0;
              shreg     <= {shreg[5:0], SPI_MISO};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                PIX_DATA  <= {shreg, SPI_MISO};
                PIX_VALID <= 1'b1;
                byte_cnt  <= byte_cnt + 1'b1;
                if (byte_cnt == BYTE_LAST) state <= FINISH;
              end
            end else if (!stall) begin
              phase_cnt <= 8'd0;
              SPI_CLK   <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        FINISH: begin
          if (PIX_VALID && PIX_READY) begin
            state <= IDLE;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_reader.sv
// Bench for spi_frame_reader: a default instance and a CLK_DIV=3 / GAP_CYCLES=0
// instance, each fed by a frame-buffer model and checked against an expected queue.
module tb_spi_frame_reader;
  localparam int NB = 9;

  logic clk = 1'b0;
  logic rst_n;

  logic start_a, miso_a = 1'b0, ready_a;
  logic spi_clk_a, cap_a, valid_a, busy_a, done_a;
  logic [7:0] data_a;
  logic [2:0] st_a;

  logic start_b, miso_b = 1'b0, ready_b;
  logic spi_clk_b, cap_b, valid_b, busy_b, done_b;
  logic [7:0] data_b;
  logic [2:0] st_b;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];

  int checks = 0, errors = 0;
  int src_a = 0, rd_a = 0, pre_a = 0, dat_a = 0, done_cnt_a = 0;
  int src_b = 0, rd_b = 0, pre_b = 0, dat_b = 0, done_cnt_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  spi_frame_reader dut_a (
    .SYSCLK(clk), .NSYSRESET(rst_n), .START(start_a), .SPI_MISO(miso_a),
    .SPI_CLK(spi_clk_a), .CAPTURE_READ(cap_a), .PIX_DATA(data_a), .PIX_VALID(valid_a),
    .PIX_READY(ready_a), .BUSY(busy_a), .DONE(done_a), .state_dbg(st_a)
  );

  spi_frame_reader #(.CLK_DIV(3), .PREAMBLE_CLKS(8), .GAP_CYCLES(0), .FRAME_BYTES(NB)) dut_b (
    .SYSCLK(clk), .NSYSRESET(rst_n), .START(start_b), .SPI_MISO(miso_b),
    .SPI_CLK(spi_clk_b), .CAPTURE_READ(cap_b), .PIX_DATA(data_b), .PIX_VALID(valid_b),
    .PIX_READY(ready_b), .BUSY(busy_b), .DONE(done_b), .state_dbg(st_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Frame buffer model: each frame is the next NB bytes of the expected queue,
  // served MSB first, one bit per data pulse; a preamble realigns to a frame start.
  always @(posedge spi_clk_a) begin
    if (cap_a) src_a = ((src_a + 8 * NB - 1) / (8 * NB)) * (8 * NB);
    else begin
      miso_a = (src_a / 8 < exp_q_a.size()) ? exp_q_a[src_a / 8][7 - src_a % 8] : 1'b0;
      src_a++;
    end
  end

  always @(posedge spi_clk_b) begin
    if (cap_b) src_b = ((src_b + 8 * NB - 1) / (8 * NB)) * (8 * NB);
    else begin
      miso_b = (src_b / 8 < exp_q_b.size()) ? exp_q_b[src_b / 8][7 - src_b % 8] : 1'b0;
      src_b++;
    end
  end

  // scoreboard and pulse counters
  always @(negedge clk) begin
    if (!rst_n) rd_a = ((rd_a + NB - 1) / NB) * NB;
    else begin
      if (spi_clk_a && !prev_a) begin
        if (cap_a) pre_a++;
        else dat_a++;
      end
      if (done_a) done_cnt_a++;
      if (valid_a && ready_a) begin
        if (rd_a < exp_q_a.size()) chk("byte_a", data_a, exp_q_a[rd_a]);
        else chk("extra_byte_a", rd_a, exp_q_a.size());
        rd_a++;
      end
    end
    prev_a = spi_clk_a;
  end

  always @(negedge clk) begin
    if (!rst_n) rd_b = ((rd_b + NB - 1) / NB) * NB;
    else begin
      if (spi_clk_b && !prev_b) begin
        if (cap_b) pre_b++;
        else dat_b++;
      end
      if (done_b) done_cnt_b++;
      if (valid_b && ready_b) begin
        if (rd_b < exp_q_b.size()) chk("byte_b", data_b, exp_q_b[rd_b]);
        else chk("extra_byte_b", rd_b, exp_q_b.size());
        rd_b++;
      end
    end
    prev_b = spi_clk_b;
  end

  // driver tasks
  task automatic push_rand_a();
    for (int i = 0; i < NB; i++) exp_q_a.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic finish_a(input int pre0, input int dat0, input int done0, input int base,
                          input bit idle_after);
    chk("done_seen", done_a, 1);
    chk("busy_with_done", busy_a, 0);
    tick();
    chk("done_single", done_a, 0);
    if (idle_after) chk("busy_after_done", busy_a, 0);
    chk("preamble_pulses", pre_a - pre0, 8);
    chk("data_pulses", dat_a - dat0, 8 * NB);
    chk("done_count", done_cnt_a - done0, 1);
    chk("bytes_consumed", rd_a - base, NB);
  endtask

  task automatic frame_a(input int bp, input int hold, input bit mid_start, input bit keep_start);
    int c, first_v, last_on, base, pre0, dat0, done0, bp_cnt, hold_cnt;
    logic vprev;
    base = exp_q_a.size() - NB;
    pre0 = pre_a; dat0 = dat_a; done0 = done_cnt_a;
    first_v = 0; last_on = 0; bp_cnt = 0; hold_cnt = 0; vprev = 1'b0;
    ready_a = (bp == 0);
    start_a = 1'b1;
    tick();
    if (!keep_start) start_a = 1'b0;
    c = 1;
    chk("setup_capture", cap_a, 1);
    chk("setup_busy", busy_a, 1);
    chk("setup_spi_clk", spi_clk_a, 0);
    while (!done_a && c < 2000) begin
      tick();
      c++;
      if (c == 16) chk("pre_last_high", spi_clk_a, 1);
      if (c == 17) begin
        chk("capture_fall", cap_a, 0);
        chk("pre_last_low", spi_clk_a, 0);
      end
      if (c == 18) chk("gap_low", spi_clk_a, 0);
      if (c == 19) chk("data_first_high", spi_clk_a, 1);
      if (mid_start && c == 60) start_a = 1'b1;
      if (mid_start && c == 61) start_a = 1'b0;
      if (valid_a && !vprev) begin
        if (first_v == 0) first_v = c;
        else if (bp == 0) chk("byte_spacing", c - last_on, 16);
        last_on = c;
      end
      vprev = valid_a;
      if (bp > 0 && first_v != 0 && bp_cnt < bp) begin
        chk("bp_data_held", data_a, exp_q_a[base]);
        chk("bp_valid_held", valid_a, 1);
        bp_cnt++;
        if (bp_cnt == bp) begin
          chk("bp_pulses_before_stall", dat_a - dat0, 15);
          chk("bp_spi_clk_low", spi_clk_a, 0);
          ready_a = 1'b1;
        end
      end
      if (hold > 0 && hold_cnt < hold) begin
        if (ready_a && rd_a == base + NB - 1) ready_a = 1'b0;
        else if (!ready_a && valid_a) begin
          chk("hold_no_done", done_a, 0);
          chk("hold_busy", busy_a, 1);
          hold_cnt++;
          if (hold_cnt == hold) ready_a = 1'b1;
        end
      end
    end
    chk("first_valid_cycle", first_v, 34);
    finish_a(pre0, dat0, done0, base, !keep_start);
  endtask

  logic [7:0] fixed_bytes [NB] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h12, 8'h34, 8'hC3};

  initial begin
    int c, base, pre0, dat0, done0, first_v, last_on;
    logic vprev;
    rst_n = 1'b0;
    start_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; ready_b = 1'b0;
    tick();
    tick();
    chk("rst_spi_clk", spi_clk_a, 0);
    chk("rst_capture", cap_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_b_spi_clk", spi_clk_b, 0);
    chk("rst_b_busy", busy_b, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // nominal frame with the fixed byte pattern
    foreach (fixed_bytes[i]) exp_q_a.push_back(fixed_bytes[i]);
    frame_a(0, 0, 0, 0);
    repeat (3) tick();

    // backpressure after byte 0, then last-byte hold
    push_rand_a();
    frame_a(20, 0, 0, 0);
    repeat (3) tick();
    push_rand_a();
    frame_a(0, 15, 0, 0);
    repeat (3) tick();

    // START pulsed mid-frame is ignored
    push_rand_a();
    frame_a(0, 0, 1, 0);
    repeat (5) tick();
    chk("mid_start_idle_busy", busy_a, 0);
    chk("mid_start_idle_capture", cap_a, 0);

    // START held high: back-to-back frames
    push_rand_a();
    frame_a(0, 0, 0, 1);
    push_rand_a();
    chk("b2b_setup_capture", cap_a, 1);
    chk("b2b_setup_busy", busy_a, 1);
    start_a = 1'b0;
    base = exp_q_a.size() - NB;
    pre0 = pre_a; dat0 = dat_a; done0 = done_cnt_a;
    c = 1;
    while (!done_a && c < 2000) begin
      tick();
      c++;
    end
    finish_a(pre0, dat0, done0, base, 1'b1);
    repeat (3) tick();

    // reset during byte 3
    push_rand_a();
    base = exp_q_a.size() - NB;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    c = 0;
    while (rd_a < base + 3 && c < 500) begin
      tick();
      c++;
    end
    chk("reached_byte3", rd_a - base, 3);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_spi_clk", spi_clk_a, 0);
    chk("midrst_capture", cap_a, 0);
    chk("midrst_data", data_a, 0);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    dat0 = dat_a;
    repeat (10) tick();
    chk("post_rst_idle_busy", busy_a, 0);
    chk("post_rst_idle_capture", cap_a, 0);
    chk("post_rst_no_pulses", dat_a - dat0, 0);
    push_rand_a();
    frame_a(0, 0, 0, 0);
    repeat (3) tick();

    // CLK_DIV=3, no gap
    for (int i = 0; i < NB; i++) exp_q_b.push_back(8'($urandom_range(0, 255)));
    base = exp_q_b.size() - NB;
    pre0 = pre_b; dat0 = dat_b; done0 = done_cnt_b;
    first_v = 0; last_on = 0; vprev = 1'b0;
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    c = 1;
    chk("b_setup_capture", cap_b, 1);
    while (!done_b && c < 4000) begin
      tick();
      c++;
      if (c >= 2 && c <= 4) chk("b_first_high_phase", spi_clk_b, 1);
      if (c == 5) chk("b_first_low_phase", spi_clk_b, 0);
      if (c == 46) chk("b_pre_last_high", spi_clk_b, 1);
      if (c == 47) begin
        chk("b_capture_fall", cap_b, 0);
        chk("b_pre_last_low", spi_clk_b, 0);
      end
      if (c == 49) chk("b_pre_low_end", spi_clk_b, 0);
      if (c == 50) chk("b_no_gap_data_high", spi_clk_b, 1);
      if (valid_b && !vprev) begin
        if (first_v == 0) first_v = c;
        else chk("b_byte_spacing", c - last_on, 48);
        last_on = c;
      end
      vprev = valid_b;
    end
    chk("b_first_valid_cycle", first_v, 95);
    chk("b_done_seen", done_b, 1);
    chk("b_busy_with_done", busy_b, 0);
    tick();
    chk("b_done_single", done_b, 0);
    chk("b_preamble_pulses", pre_b - pre0, 8);
    chk("b_data_pulses", dat_b - dat0, 8 * NB);
    chk("b_done_count", done_cnt_b - done0, 1);
    chk("b_bytes_consumed", rd_b - base, NB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
